// File: rtl/accum_seq_ctrl_pkg.sv
// accum_seq_ctrl_pkg: FSM state encoding and default hazard window shared by the accum_seq_ctrl slice
package accum_seq_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  localparam int HAZ_WIN_DEF = 3;
endpackage

// File: rtl/accum_seq_ctrl_if.sv
// accum_seq_ctrl_if: job config, upstream beat, accumulator bundle and status signals of accum_seq_ctrl
interface accum_seq_ctrl_if #(
  parameter int DATAW = 32,
  parameter int ADDRW = 9,
  parameter int SUBW = 8
);
  logic i_cfg_valid;
  logic [ADDRW:0] i_cfg_rows;
  logic [SUBW-1:0] i_cfg_subsets;
  logic o_cfg_ready;
  logic i_valid;
  logic [DATAW-1:0] i_data;
  logic o_ready;
  logic o_acc_valid;
  logic [DATAW-1:0] o_acc_data;
  logic [ADDRW-1:0] o_acc_addr;
  logic o_acc_accum;
  logic o_acc_last;
  logic i_res_valid;
  logic o_busy;
  logic o_done;
  modport slave (
    input i_cfg_valid, i_cfg_rows, i_cfg_subsets, i_valid, i_data, i_res_valid,
    output o_cfg_ready, o_ready, o_acc_valid, o_acc_data, o_acc_addr, o_acc_accum, o_acc_last, o_busy, o_done
  );
  modport master (
    output i_cfg_valid, i_cfg_rows, i_cfg_subsets, i_valid, i_data, i_res_valid,
    input o_cfg_ready, o_ready, o_acc_valid, o_acc_data, o_acc_addr, o_acc_accum, o_acc_last, o_busy, o_done
  );
endinterface

// File: rtl/accum_seq_ctrl_hazard_sb.sv
// accum_hazard_sb: HAZ_WIN-deep history of recently accepted rows with a same-row match flag
module accum_hazard_sb #(
  parameter int ADDRW = 9,
  parameter int HAZ_WIN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [ADDRW-1:0] addr_i,
  output logic             match_o
);
  logic [HAZ_WIN-1:0] vld_q;
  logic [ADDRW-1:0] addr_q [HAZ_WIN];
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      vld_q <= '0;
      for (int i = 0; i < HAZ_WIN; i++) addr_q[i] <= '0;
    end else begin
      vld_q[0] <= push_i;
      addr_q[0] <= addr_i;
      for (int i = 1; i < HAZ_WIN; i++) begin
        vld_q[i] <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end
  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++) match_o = match_o | (vld_q[i] && addr_q[i] == addr_i);
  end
endmodule

// File: rtl/accum_seq_ctrl.sv
// accum_seq_ctrl: tags DPE beats for the accumulator and stalls row re-reads; ACCUM_SEQ_CTRL_PERF_EN adds stall/beat counters
module accum_seq_ctrl
  import accum_seq_ctrl_pkg::*;
#(
  parameter int DATAW = 32,
  parameter int DEPTH = 512,
  parameter int ADDRW = $clog2(DEPTH),
  parameter int SUBW = 8,
  parameter int HAZ_WIN = HAZ_WIN_DEF
) (
  input logic clk,
  input logic rst,
  accum_seq_ctrl_if.slave bus
`ifdef ACCUM_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_beats
`endif
);
  localparam logic [ADDRW:0] HAZ_R = (ADDRW+1)'(HAZ_WIN);
  state_e state_q, state_d;
  logic [ADDRW:0] rows_q, rows_d, row_q, row_d, res_q, res_d;
  logic [SUBW-1:0] subs_q, subs_d, sub_q, sub_d;
  logic done_q, done_d, match, ready, accept, cfg_acc, row_wrap, sub_last;
  logic acc_valid_q, acc_accum_q, acc_last_q;
  logic [DATAW-1:0] acc_data_q;
  logic [ADDRW-1:0] acc_addr_q;
  assign cfg_acc = state_q == IDLE && bus.i_cfg_valid;
  assign row_wrap = row_q == rows_q - 1'b1;
  assign sub_last = sub_q == subs_q - 1'b1;
  // a short job revisits a row while its partial sum is still in flight
  assign ready = state_q == RUN && !(match && sub_q != '0 && rows_q <= HAZ_R);
  assign accept = bus.i_valid && ready;
  accum_hazard_sb #(.ADDRW(ADDRW), .HAZ_WIN(HAZ_WIN)) u_sb (
    .clk(clk),
    .rst(rst),
    .flush_i(cfg_acc),
    .push_i(accept),
    .addr_i(row_q[ADDRW-1:0]),
    .match_o(match)
  );
  always_comb begin
    state_d = state_q;
    rows_d = rows_q;
    subs_d = subs_q;
    row_d = row_q;
    sub_d = sub_q;
    res_d = (state_q != IDLE && bus.i_res_valid) ? res_q + 1'b1 : res_q;
    done_d = 1'b0;
    if (cfg_acc) begin
      rows_d = bus.i_cfg_rows;
      subs_d = bus.i_cfg_subsets;
      row_d = '0;
      sub_d = '0;
      res_d = '0;
      done_d = bus.i_cfg_rows == '0 || bus.i_cfg_subsets == '0;
      state_d = done_d ? IDLE : RUN;
    end else if (accept) begin
      row_d = row_wrap ? '0 : row_q + 1'b1;
      sub_d = row_wrap ? sub_q + 1'b1 : sub_q;
      state_d = (row_wrap && sub_last) ? DRAIN : RUN;
    end else if (state_q == DRAIN && res_d >= rows_q) begin
      state_d = IDLE;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rows_q <= '0;
      subs_q <= '0;
      row_q <= '0;
      sub_q <= '0;
      res_q <= '0;
      done_q <= 1'b0;
      acc_valid_q <= 1'b0;
      acc_data_q <= '0;
      acc_addr_q <= '0;
      acc_accum_q <= 1'b0;
      acc_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q <= rows_d;
      subs_q <= subs_d;
      row_q <= row_d;
      sub_q <= sub_d;
      res_q <= res_d;
      done_q <= done_d;
      acc_valid_q <= accept;
      if (accept) begin
        acc_data_q <= bus.i_data;
        acc_addr_q <= row_q[ADDRW-1:0];
        acc_accum_q <= sub_q != '0;
        acc_last_q <= sub_last;
      end
    end
  end
  assign bus.o_ready = ready;
  assign bus.o_cfg_ready = state_q == IDLE;
  assign bus.o_busy = state_q != IDLE;
  assign bus.o_done = done_q;
  assign bus.o_acc_valid = acc_valid_q;
  assign bus.o_acc_data = acc_data_q;
  assign bus.o_acc_addr = acc_addr_q;
  assign bus.o_acc_accum = acc_accum_q;
  assign bus.o_acc_last = acc_last_q;
`ifdef ACCUM_SEQ_CTRL_PERF_EN
  logic [31:0] stall_q, beats_q;
  always_ff @(posedge clk) begin
    if (rst || cfg_acc) begin
      stall_q <= '0;
      beats_q <= '0;
    end else begin
      if (state_q == RUN && bus.i_valid && !ready && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (accept && !(&beats_q)) beats_q <= beats_q + 1'b1;
    end
  end
  assign o_stall_cycles = stall_q;
  assign o_beats = beats_q;
`endif
endmodule

// File: tb/tb_accum_seq_ctrl.sv
// tb_accum_seq_ctrl: table-driven and randomized jobs checked against a cycle-timed row-reuse model
module tb_accum_seq_ctrl;
  localparam int DATAW = 32;
  localparam int ADDRW = 9;
  localparam int SUBW = 8;
  localparam int HW = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  accum_seq_ctrl_if #(.DATAW(DATAW), .ADDRW(ADDRW), .SUBW(SUBW)) ifc ();
`ifdef ACCUM_SEQ_CTRL_PERF_EN
  logic [31:0] stall_cnt, beat_cnt;
`endif
  accum_seq_ctrl #(.DATAW(DATAW), .DEPTH(512), .SUBW(SUBW), .HAZ_WIN(HW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
`ifdef ACCUM_SEQ_CTRL_PERF_EN
    ,
    .o_stall_cycles(stall_cnt),
    .o_beats(beat_cnt)
`endif
  );
  always #5 clk = ~clk;

  typedef struct {
    int r;
    int s;
    int beats;
    int stalls;
    int span;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beats follow from the job shape; a beat may only be taken once its
  // row was last taken more than HW cycles earlier (short jobs, accumulating beats).
  task automatic run_job(input int r, input int s, input int vpct, input bit noisy,
                         output int n_acc, output int n_stall, output int span);
    int last_acc [int];
    int t, first, nb, addr, pa;
    bit accum, haz, pend, pacc, plast;
    logic [DATAW-1:0] pd;
    t = 0;
    first = -1;
    nb = r * s;
    pend = 1'b0;
    pa = 0;
    pacc = 1'b0;
    plast = 1'b0;
    pd = '0;
    n_acc = 0;
    n_stall = 0;
    span = -1;
    ifc.i_cfg_valid = 1'b1;
    ifc.i_cfg_rows = (ADDRW+1)'(r);
    ifc.i_cfg_subsets = SUBW'(s);
    tick();
    ifc.i_cfg_valid = 1'b0;
    if (nb == 0) begin
      chk("zero_done", ifc.o_done, 1);
      chk("zero_busy", ifc.o_busy, 0);
      chk("zero_accv", ifc.o_acc_valid, 0);
      tick();
      chk("zero_done_drop", ifc.o_done, 0);
      chk("zero_accv2", ifc.o_acc_valid, 0);
      return;
    end
    chk("run_busy", ifc.o_busy, 1);
    chk("run_cfg_ready", ifc.o_cfg_ready, 0);
    while (n_acc < nb && t < 2000) begin
      addr = n_acc % r;
      accum = n_acc >= r;
      haz = accum && r <= HW && last_acc.exists(addr) && (t - last_acc[addr] <= HW);
      ifc.i_valid = $urandom_range(99) < vpct;
      ifc.i_data = $urandom;
      ifc.i_cfg_valid = noisy && ($urandom_range(3) == 0);
      ifc.i_cfg_rows = (ADDRW+1)'($urandom);
      ifc.i_cfg_subsets = SUBW'($urandom);
      #1;
      chk("ready", ifc.o_ready, !haz);
      if (ifc.i_valid && ifc.o_ready) begin
        pend = 1'b1;
        pd = ifc.i_data;
        pa = addr;
        pacc = accum;
        plast = n_acc >= nb - r;
        last_acc[addr] = t;
        if (first < 0) first = t;
        span = t - first;
        n_acc++;
      end else begin
        pend = 1'b0;
        if (ifc.i_valid) n_stall++;
      end
      tick();
      t++;
      chk("acc_valid", ifc.o_acc_valid, pend);
      if (pend) begin
        chk("acc_addr", ifc.o_acc_addr, pa);
        chk("acc_accum", ifc.o_acc_accum, pacc);
        chk("acc_last", ifc.o_acc_last, plast);
        chk("acc_data", ifc.o_acc_data, pd);
      end
    end
    chk("run_all_beats", n_acc, nb);
    ifc.i_cfg_valid = 1'b0;
    ifc.i_valid = 1'b1;
    #1;
    chk("drain_ready", ifc.o_ready, 0);
    chk("drain_busy", ifc.o_busy, 1);
    ifc.i_valid = 1'b0;
    for (int k = 0; k < r; k++) begin
      repeat ($urandom_range(2)) begin
        tick();
        chk("drain_wait_done", ifc.o_done, 0);
        chk("drain_accv", ifc.o_acc_valid, 0);
      end
      ifc.i_res_valid = 1'b1;
      tick();
      ifc.i_res_valid = 1'b0;
      chk("done", ifc.o_done, k == r - 1);
      chk("busy_end", ifc.o_busy, k != r - 1);
    end
    chk("cfg_ready_end", ifc.o_cfg_ready, 1);
    tick();
    chk("done_pulse", ifc.o_done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int na, ns, sp, r, s;
    tbl[0] = '{4, 3, 12, 0, 11};
    tbl[1] = '{1, 3, 3, 6, 8};
    tbl[2] = '{2, 2, 4, 2, 5};
    tbl[3] = '{3, 2, 6, 1, 6};
    tbl[4] = '{5, 2, 10, 0, 9};
    tbl[5] = '{1, 1, 1, 0, 0};
    tbl[6] = '{0, 3, 0, 0, -1};
    tbl[7] = '{3, 0, 0, 0, -1};
    tbl[8] = '{512, 1, 512, 0, 511};
    ifc.i_cfg_valid = 1'b0;
    ifc.i_cfg_rows = '0;
    ifc.i_cfg_subsets = '0;
    ifc.i_valid = 1'b1;
    ifc.i_data = '0;
    ifc.i_res_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_accv", ifc.o_acc_valid, 0);
    chk("rst_addr", ifc.o_acc_addr, 0);
    chk("rst_data", ifc.o_acc_data, 0);
    chk("rst_accum", ifc.o_acc_accum, 0);
    chk("rst_last", ifc.o_acc_last, 0);
    chk("rst_ready", ifc.o_ready, 0);
    chk("rst_busy", ifc.o_busy, 0);
    chk("rst_done", ifc.o_done, 0);
    chk("rst_cfg_ready", ifc.o_cfg_ready, 1);
    ifc.i_valid = 1'b0;
    tick();
    foreach (tbl[i]) begin
      run_job(tbl[i].r, tbl[i].s, 100, 1'b0, na, ns, sp);
      chk($sformatf("tbl%0d_beats", i), na, tbl[i].beats);
      chk($sformatf("tbl%0d_stalls", i), ns, tbl[i].stalls);
      chk($sformatf("tbl%0d_span", i), sp, tbl[i].span);
`ifdef ACCUM_SEQ_CTRL_PERF_EN
      chk($sformatf("tbl%0d_perf_beats", i), beat_cnt, tbl[i].beats);
      chk($sformatf("tbl%0d_perf_stalls", i), stall_cnt, tbl[i].stalls);
`endif
      tick();
    end
    ifc.i_cfg_valid = 1'b1;
    ifc.i_cfg_rows = 10'd4;
    ifc.i_cfg_subsets = 8'd3;
    tick();
    ifc.i_cfg_valid = 1'b0;
    ifc.i_valid = 1'b1;
    repeat (5) tick();
    chk("mid_accv", ifc.o_acc_valid, 1);
    chk("mid_addr", ifc.o_acc_addr, 0);
    chk("mid_accum", ifc.o_acc_accum, 1);
    ifc.i_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", ifc.o_busy, 0);
    chk("abort_cfg_ready", ifc.o_cfg_ready, 1);
    chk("abort_accv", ifc.o_acc_valid, 0);
    chk("abort_done", ifc.o_done, 0);
    ifc.i_res_valid = 1'b1;
    repeat (4) begin
      tick();
      chk("abort_no_done", ifc.o_done, 0);
      chk("abort_idle", ifc.o_busy, 0);
    end
    ifc.i_res_valid = 1'b0;
    run_job(2, 1, 100, 1'b0, na, ns, sp);
    chk("restart_beats", na, 2);
    chk("restart_stalls", ns, 0);
    for (int j = 0; j < 20; j++) begin
      r = $urandom_range(6, 1);
      s = $urandom_range(4, 1);
      run_job(r, s, 60, 1'b1, na, ns, sp);
      chk("rand_beats", na, r * s);
      repeat ($urandom_range(2)) tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
